// File: rtl/button_pkg.sv
// Shared types and widths for the push-button capture block.
package button_pkg;

  localparam int unsigned PRESS_CNT_W = 16;
  localparam int unsigned STAB_CNT_W  = 24;
  localparam int unsigned STATUS_W    = 32;
  localparam int unsigned PENDING_BIT = 0;
  localparam int unsigned COUNT_LSB   = 16;
  localparam int unsigned RSVD_W      = COUNT_LSB - PENDING_BIT - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD      = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  // Processor-visible status word: count in the top half, pending in bit 0.
  typedef struct packed {
    logic [PRESS_CNT_W-1:0] count;
    logic [RSVD_W-1:0]      rsvd;
    logic                   pending;
  } status_t;

  function automatic status_t pack_status(input logic [PRESS_CNT_W-1:0] cnt,
                                          input logic                   pend);
    status_t s;
    s         = '0;
    s.count   = cnt;
    s.pending = pend;
    return s;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level, async reset to 0.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/button_press_capture.sv
// Debounces a raw push-button, strobes once per accepted press and keeps a
// pending flag plus an optional press count (enabled by BUTTON_PRESS_COUNT_EN).
module button_press_capture
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                button,
  input  logic                clear,
  output logic [STATUS_W-1:0] buttonPressed,
  output logic                press_pulse,
  output logic                debounced
);

  localparam logic [STAB_CNT_W-1:0] STAB_LAST = STAB_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STAB_CNT_W-1:0] STAB_ONE  = STAB_CNT_W'(1);

  logic                   btn_sync;
  btn_state_e             state_q, state_d;
  logic [STAB_CNT_W-1:0]  stab_cnt_q, stab_cnt_d;
  logic                   press_d;
  logic                   debounced_d;
  logic                   pending_q;
  logic [PRESS_CNT_W-1:0] press_cnt;
  status_t                status;

  sync2 u_sync2 (
    .clock (clock),
    .reset (reset),
    .d     (button),
    .q     (btn_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // The entry sample counts as the first stable one, so the last accepted
  // sample is the one that arrives while the counter holds DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    press_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d    = WAIT_HIGH;
          stab_cnt_d = STAB_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!btn_sync) begin
          state_d    = IDLE;
          stab_cnt_d = '0;
        end else if (stab_cnt_q >= STAB_LAST) begin
          state_d    = HELD;
          stab_cnt_d = '0;
          press_d    = 1'b1;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end
      HELD: begin
        if (!btn_sync) begin
          state_d    = WAIT_LOW;
          stab_cnt_d = STAB_ONE;
        end
      end
      WAIT_LOW: begin
        if (btn_sync) begin
          state_d    = HELD;
          stab_cnt_d = '0;
        end else if (stab_cnt_q >= STAB_LAST) begin
          state_d    = IDLE;
          stab_cnt_d = '0;
        end else begin
          stab_cnt_d = stab_cnt_q + STAB_ONE;
        end
      end
      default: begin
        state_d    = IDLE;
        stab_cnt_d = '0;
      end
    endcase
    debounced_d = (state_d == HELD) || (state_d == WAIT_LOW);
  end

  // A press in the same cycle as clear keeps pending set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_pulse <= 1'b0;
      debounced   <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      press_pulse <= press_d;
      debounced   <= debounced_d;
      if (press_d) begin
        pending_q <= 1'b1;
      end else if (clear) begin
        pending_q <= 1'b0;
      end
    end
  end

`ifdef BUTTON_PRESS_COUNT_EN
  logic [PRESS_CNT_W-1:0] press_cnt_q;

  // Free-running wrap; independent of pending and clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      press_cnt_q <= '0;
    end else if (press_d) begin
      press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
    end
  end

  assign press_cnt = press_cnt_q;
`else
  assign press_cnt = '0;
`endif

  assign status        = pack_status(press_cnt, pending_q);
  assign buttonPressed = status;

endmodule

// File: tb/tb_button_press_capture.sv
// Directed self-checking bench for button_press_capture (DEBOUNCE_CYCLES = 4).
module tb_button_press_capture;

  localparam int unsigned DEB = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        button;
  logic        clear;
  logic [31:0] buttonPressed;
  logic        press_pulse;
  logic        debounced;

  int          checks   = 0;
  int          failures = 0;
  int          pulses   = 0;
  logic [15:0] m_cnt;
  logic        m_pend;

  button_press_capture #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock         (clock),
    .reset         (reset),
    .button        (button),
    .clear         (clear),
    .buttonPressed (buttonPressed),
    .press_pulse   (press_pulse),
    .debounced     (debounced)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_word(input logic [15:0] c, input logic p);
    logic [15:0] cc;
    cc = c;
`ifndef BUTTON_PRESS_COUNT_EN
    cc = 16'd0;
`endif
    return {cc, 15'd0, p};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1 time unit after each and tallying pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      if (press_pulse === 1'b1) pulses++;
    end
  endtask

  initial begin
    reset  = 1'b0;
    button = 1'b0;
    clear  = 1'b0;
    m_cnt  = 16'd0;
    m_pend = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_word",  buttonPressed,     32'h0);
    check("reset_pulse", 32'(press_pulse),  32'h0);
    check("reset_deb",   32'(debounced),    32'h0);
    step(2);
    reset = 1'b0;
    step(2);
    check("idle_word", buttonPressed, exp_word(m_cnt, m_pend));

    // Bounce 1,0,1,0 then low: nothing accepted.
    pulses = 0;
    button = 1'b1; step(1);
    button = 1'b0; step(1);
    button = 1'b1; step(1);
    button = 1'b0; step(12);
    check("bounce_pulses", 32'(pulses),    32'd0);
    check("bounce_word",   buttonPressed,  exp_word(16'd0, 1'b0));
    check("bounce_deb",    32'(debounced), 32'h0);

    // Clean press: pulse after sync edge N + 1 + DEB.
    pulses = 0;
    button = 1'b1;
    step(5);
    check("press_early", 32'(press_pulse), 32'h0);
    step(1);
    m_cnt++; m_pend = 1'b1;
    check("press_pulse", 32'(press_pulse), 32'h1);
    check("press_word",  buttonPressed,    exp_word(m_cnt, m_pend));
    check("press_deb",   32'(debounced),   32'h1);
    step(1);
    check("pulse_width", 32'(press_pulse), 32'h0);
    step(13);
    check("hold_pulses", 32'(pulses),   32'd1);
    check("hold_word",   buttonPressed, exp_word(m_cnt, m_pend));

    // Release: debounced stays high until the low level is debounced.
    button = 1'b0;
    step(5);
    check("rel_deb_hold", 32'(debounced), 32'h1);
    step(1);
    check("rel_deb_low",  32'(debounced), 32'h0);
    step(4);
    check("rel_pulses",   32'(pulses),    32'd1);

    // Clear alone drops pending and keeps the count.
    clear = 1'b1; step(1); clear = 1'b0;
    m_pend = 1'b0;
    check("clear_word", buttonPressed, exp_word(m_cnt, m_pend));

    // Clear sampled on the same edge as a press: press wins.
    button = 1'b1;
    step(5);
    clear = 1'b1;
    step(1);
    m_cnt++; m_pend = 1'b1;
    check("coll_pulse", 32'(press_pulse), 32'h1);
    check("coll_word",  buttonPressed,    exp_word(m_cnt, m_pend));
    step(1);
    clear = 1'b0;
    m_pend = 1'b0;
    check("coll_clear_word", buttonPressed, exp_word(m_cnt, m_pend));
    button = 1'b0;
    step(8);

    // Count wrap from 0xFFFF (counter preloaded directly when it exists).
`ifdef BUTTON_PRESS_COUNT_EN
    force dut.press_cnt_q = 16'hFFFF;
    #1;
    release dut.press_cnt_q;
    m_cnt = 16'hFFFF;
`endif
    button = 1'b1;
    step(6);
    m_cnt++; m_pend = 1'b1;
    check("wrap_word", buttonPressed, exp_word(m_cnt, m_pend));
    button = 1'b0;
    step(8);
    check("wrap_rel_deb", 32'(debounced), 32'h0);

    // Async reset mid-WAIT_HIGH with the button held through reset.
    button = 1'b1;
    step(4);
    check("pre_reset_word", buttonPressed, exp_word(m_cnt, 1'b1));
    #2 reset = 1'b1;
    #1;
    check("async_word",  buttonPressed,    32'h0);
    check("async_pulse", 32'(press_pulse), 32'h0);
    check("async_deb",   32'(debounced),   32'h0);
    #1 reset = 1'b0;
    m_cnt = 16'd0; m_pend = 1'b0;
    pulses = 0;
    step(5);
    check("post_reset_early", 32'(press_pulse), 32'h0);
    step(1);
    m_cnt++; m_pend = 1'b1;
    check("post_reset_pulse", 32'(press_pulse), 32'h1);
    check("post_reset_word",  buttonPressed,    exp_word(m_cnt, m_pend));
    button = 1'b0;
    step(8);
    check("post_reset_pulses", 32'(pulses), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_press_capture.md
BUTTON_PRESS_CAPTURE -- requirements
Module: button_press_capture

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive stable synchronized samples (10 ms at 100 MHz) required to accept a level change; the legal range is 2..2^24-1.
REQ-002 The block SHALL have port clock, input, 1 bit: the single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port button, input, 1 bit: raw asynchronous push-button level, active high.
REQ-005 The block SHALL have port clear, input, 1 bit: synchronous acknowledge from the processor side that drops the pending flag.
REQ-006 The block SHALL have port buttonPressed, output, 32 bits: status word, with bit0 = pending, bits[15:1] = 0, bits[31:16] = press count.
REQ-007 The block SHALL have port press_pulse, output, 1 bit: one-cycle strobe for each accepted press.
REQ-008 The block SHALL have port debounced, output, 1 bit: the current debounced button level.

Function
REQ-009 The block SHALL pass button through a 2-flop synchronizer before any other logic.
REQ-010 The block SHALL implement FSM states IDLE (stable low), WAIT_HIGH, HELD (stable high) and WAIT_LOW.
REQ-011 The FSM SHALL move IDLE->WAIT_HIGH on a synced 1 and HELD->WAIT_LOW on a synced 0, loading the stability counter with 1.
REQ-012 In WAIT_HIGH/WAIT_LOW, the FSM SHALL increment the counter on a matching sample and return to the prior stable state on a mismatching sample (bounce), with the counter cleared.
REQ-013 WAIT_HIGH SHALL go to HELD when the counter reaches DEBOUNCE_CYCLES, and WAIT_LOW SHALL go to IDLE on the same condition.
REQ-014 On the WAIT_HIGH->HELD edge, the block SHALL assert press_pulse for exactly one cycle, set pending, and increment the count.
REQ-015 Latency: for a clean rise first captured by the sync flop at edge N, press_pulse and pending SHALL be high after edge N+1+DEBOUNCE_CYCLES.
REQ-016 Releases SHALL generate no pulse, and holding the button SHALL generate exactly one press.
REQ-017 The debounced output SHALL be 1 in HELD and WAIT_LOW, and 0 otherwise.
REQ-018 Clear SHALL drop pending on the next edge.
REQ-019 If clear and a press occur in the same cycle, the press SHALL win: pending stays 1 and the count still increments.
REQ-020 The press count SHALL be 16 bits, unsigned, and wrap 0xFFFF->0x0000 without affecting pending; clear SHALL NOT reset the count.
REQ-021 The stability counter SHALL be 24 bits and SHALL never exceed DEBOUNCE_CYCLES.

Reset
REQ-022 Assertion of reset SHALL immediately force the synchronizer flops to 0, the state to IDLE, the counters to 0, pending to 0, press_pulse to 0, and buttonPressed to 0x00000000.
REQ-023 Reset mid-debounce SHALL discard the partial count, and a button held through reset release SHALL be accepted as a new press after full debounce.

Configuration
REQ-024 The macro BUTTON_PRESS_COUNT_EN SHALL control the press counter. When defined, the 16-bit counter is built and drives bits[31:16]. When undefined, no counter is built and bits[31:16] are tied to 0; all other behaviour is identical.

Structure
REQ-025 A shared package button_pkg SHALL hold the FSM state enum (IDLE, WAIT_HIGH, HELD, WAIT_LOW), PRESS_CNT_W = 16, STAB_CNT_W = 24, and the bit positions PENDING_BIT = 0 and COUNT_LSB = 16.
REQ-026 The synchronizer SHALL be a sub-module named sync2 (2-flop, async reset to 0).

Verification (DEBOUNCE_CYCLES = 4 unless stated)
REQ-027 Clean press: button rises and is held 20 cycles -> one press_pulse at the REQ-015 edge, buttonPressed = 0x00010001, debounced = 1 until 4 cycles after release.
REQ-028 Bounce: button toggles 1,0,1,0 at 1-cycle spacing, then stays low -> no press_pulse, pending = 0, count = 0.
REQ-029 Clear collision: clear is asserted in the press_pulse cycle of a second press -> pending = 1, buttonPressed = 0x00020001; clear alone one cycle later -> 0x00020000.
REQ-030 Wrap: the count is preloaded to 0xFFFF via 65535 presses (DEBOUNCE_CYCLES = 2), then one more press -> bits[31:16] = 0x0000, bit0 = 1.
REQ-031 Async reset: reset is pulsed mid-WAIT_HIGH while the button is held -> outputs are 0 before the next clock edge; after release a press is accepted after a full debounce period (REQ-015 latency).
REQ-032 Macro off: REQ-027 is repeated without BUTTON_PRESS_COUNT_EN -> buttonPressed = 0x00000001.
